// File: rtl/stim_controller_if.sv
// Feature bus into the stimulation controller: three signed features with
// their one-cycle valid strobes and the runtime thresholds they are judged against.
interface stim_controller_if #(
    parameter int unsigned LL_WIDTH   = 25,
    parameter int unsigned FEAT_WIDTH = 40
);
    logic signed [LL_WIDTH-1:0]   din_ll;
    logic signed [FEAT_WIDTH-1:0] din_ne;
    logic signed [FEAT_WIDTH-1:0] din_ps;
    logic                         data_ready_ll;
    logic                         data_ready_ne;
    logic                         data_ready_ps;
    logic signed [LL_WIDTH-1:0]   thr_ll;
    logic signed [FEAT_WIDTH-1:0] thr_ne;
    logic signed [FEAT_WIDTH-1:0] thr_ps;

    modport master (
        output din_ll, din_ne, din_ps,
        output data_ready_ll, data_ready_ne, data_ready_ps,
        output thr_ll, thr_ne, thr_ps
    );

    modport slave (
        input din_ll, din_ne, din_ps,
        input data_ready_ll, data_ready_ne, data_ready_ps,
        input thr_ll, thr_ne, thr_ps
    );
endinterface

// File: rtl/stim_controller.sv
// Stimulation decision logic: per-feature threshold compare, window alignment,
// M-of-3 vote, consecutive-window detection, then stimulation pulse and refractory hold-off.
module stim_controller #(
    parameter int unsigned LL_WIDTH       = 25,
    parameter int unsigned FEAT_WIDTH     = 40,
    parameter int unsigned VOTE_MIN       = 2,
    parameter int unsigned DETECT_CNT     = 3,
    parameter int unsigned STIM_CYCLES    = 1000,
    parameter int unsigned REFRACT_CYCLES = 5000,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    stim_controller_if.slave     feat,
    output logic                 stimulation,
    output logic [1:0]           state,
    output logic                 overrun
);

    localparam int unsigned HIT_W     = $clog2(DETECT_CNT + 1);
    localparam bit          FIRE_NOW  = (DETECT_CNT == 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        STIM    = 2'd2,
        REFRACT = 2'd3
    } state_e;

    // Bit order for the per-feature vectors: 0 = ll, 1 = ne, 2 = ps
    logic signed [LL_WIDTH-1:0]   din_ll;
    logic signed [LL_WIDTH-1:0]   thr_ll;
    logic signed [FEAT_WIDTH-1:0] din_ne;
    logic signed [FEAT_WIDTH-1:0] thr_ne;
    logic signed [FEAT_WIDTH-1:0] din_ps;
    logic signed [FEAT_WIDTH-1:0] thr_ps;
    logic [2:0]                   strobe;
    logic [2:0]                   cmp;
    logic [2:0]                   all_hits;
    logic [1:0]                   votes;
    logic                         all_set;

    logic [2:0]           flag_q, flag_d;
    logic [2:0]           hit_q, hit_d;
    logic                 win_valid_q, win_valid_d;
    logic                 win_pos_q, win_pos_d;
    logic                 ovr_q, ovr_d;
    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [HIT_W-1:0]     hcnt_q, hcnt_d;
    logic [HIT_W-1:0]     hit_inc;

    assign din_ll = feat.din_ll;
    assign thr_ll = feat.thr_ll;
    assign din_ne = feat.din_ne;
    assign thr_ne = feat.thr_ne;
    assign din_ps = feat.din_ps;
    assign thr_ps = feat.thr_ps;

    assign strobe   = {feat.data_ready_ps, feat.data_ready_ne, feat.data_ready_ll} & {3{~en}};
    assign cmp      = {(din_ps > thr_ps), (din_ne > thr_ne), (din_ll > thr_ll)};
    assign all_hits = hit_q;
    assign votes    = 2'(all_hits[0]) + 2'(all_hits[1]) + 2'(all_hits[2]);
    assign all_set  = &flag_q;
    assign hit_inc  = hcnt_q + HIT_W'(1);

    // Window collection: latch per-feature hits, close the window once all three arrived
    always_comb begin
        flag_d      = flag_q;
        hit_d       = hit_q;
        win_valid_d = win_valid_q;
        win_pos_d   = win_pos_q;
        ovr_d       = 1'b0;
        if (!en) begin
            win_valid_d = all_set;
            if (all_set) begin
                flag_d    = '0;
                win_pos_d = (votes >= 2'(VOTE_MIN));
            end
            // A strobe in the clearing cycle opens the next window instead of being dropped
            for (int i = 0; i < 3; i++) begin
                if (strobe[i]) begin
                    hit_d[i]  = cmp[i];
                    flag_d[i] = 1'b1;
                    if (flag_q[i] && !all_set) begin
                        ovr_d = 1'b1;
                    end
                end
            end
        end
    end

    // Detection / stimulation / refractory sequencing, advanced by closed windows
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hcnt_d  = hcnt_q;
        if (!en) begin
            case (state_q)
                IDLE: begin
                    if (win_valid_q && win_pos_q) begin
                        cnt_d = '0;
                        if (FIRE_NOW) begin
                            state_d = STIM;
                            hcnt_d  = '0;
                        end else begin
                            state_d = ARMED;
                            hcnt_d  = HIT_W'(1);
                        end
                    end
                end
                ARMED: begin
                    if (win_valid_q) begin
                        cnt_d = '0;
                        if (!win_pos_q) begin
                            state_d = IDLE;
                            hcnt_d  = '0;
                        end else if (hit_inc == HIT_W'(DETECT_CNT)) begin
                            state_d = STIM;
                            hcnt_d  = '0;
                        end else begin
                            hcnt_d  = hit_inc;
                        end
                    end
                end
                STIM: begin
                    if (cnt_q == CNT_WIDTH'(STIM_CYCLES - 1)) begin
                        state_d = REFRACT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + CNT_WIDTH'(1);
                    end
                end
                REFRACT: begin
                    if (cnt_q == CNT_WIDTH'(REFRACT_CYCLES - 1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        hcnt_d  = '0;
                    end else begin
                        cnt_d   = cnt_q + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    hcnt_d  = '0;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flag_q      <= '0;
            hit_q       <= '0;
            win_valid_q <= 1'b0;
            win_pos_q   <= 1'b0;
            ovr_q       <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            hcnt_q      <= '0;
        end else begin
            flag_q      <= flag_d;
            hit_q       <= hit_d;
            win_valid_q <= win_valid_d;
            win_pos_q   <= win_pos_d;
            ovr_q       <= ovr_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hcnt_q      <= hcnt_d;
        end
    end

    // Stimulation is a pure decode of the state register, gated off while frozen
    assign stimulation = (state_q == STIM) && !en;
    assign state       = state_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_stim_controller.sv
// Bench for stim_controller: vote/compare table, firing latency and duration,
// overrun, ignored windows, reset and freeze while stimulating.
module tb_stim_controller;

    localparam int unsigned LLW = 25;
    localparam int unsigned FW  = 40;
    localparam int unsigned SC  = 40;
    localparam int unsigned RC  = 100;

    localparam logic signed [LLW-1:0] THR_LL = 25'sh0000100;
    localparam logic signed [LLW-1:0] HI_LL  = 25'sh0000200;
    localparam logic signed [LLW-1:0] LO_LL  = 25'sh0000010;
    localparam logic signed [FW-1:0]  THR_F  = 40'sd1000;
    localparam logic signed [FW-1:0]  HI_F   = 40'sd2000;
    localparam logic signed [FW-1:0]  LO_F   = -40'sd3000;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       stimulation;
    logic [1:0] state;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int stim_hi = 0;
    int refr_hi = 0;
    int ovr_cnt = 0;

    logic [1:0] exp_q[$];

    typedef struct {
        logic signed [LLW-1:0] ll;
        logic signed [LLW-1:0] thr;
        logic signed [FW-1:0]  ne;
        logic signed [FW-1:0]  ps;
        logic [1:0]            st;
    } vec_t;

    vec_t tbl[11];

    stim_controller_if #(.LL_WIDTH(LLW), .FEAT_WIDTH(FW)) feat();

    stim_controller #(
        .LL_WIDTH(LLW), .FEAT_WIDTH(FW), .VOTE_MIN(2), .DETECT_CNT(3),
        .STIM_CYCLES(SC), .REFRACT_CYCLES(RC), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .feat(feat),
        .stimulation(stimulation), .state(state), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (stimulation) stim_hi++;
        if (state == 2'd3) refr_hi++;
        if (overrun) ovr_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic strobe_ll(input logic signed [LLW-1:0] v);
        feat.din_ll = v; feat.data_ready_ll = 1'b1; step(); feat.data_ready_ll = 1'b0;
    endtask

    task automatic strobe_ne(input logic signed [FW-1:0] v);
        feat.din_ne = v; feat.data_ready_ne = 1'b1; step(); feat.data_ready_ne = 1'b0;
    endtask

    task automatic strobe_ps(input logic signed [FW-1:0] v);
        feat.din_ps = v; feat.data_ready_ps = 1'b1; step(); feat.data_ready_ps = 1'b0;
    endtask

    task automatic send_window(input logic signed [LLW-1:0] ll, input logic signed [LLW-1:0] thr,
                               input logic signed [FW-1:0] ne, input logic signed [FW-1:0] ps);
        feat.thr_ll = thr;
        strobe_ll(ll);
        strobe_ne(ne);
        strobe_ps(ps);
    endtask

    // Drive one full window, expect the resulting state two cycles after its last strobe
    task automatic run_window(input string name, input logic signed [LLW-1:0] ll,
                              input logic signed [LLW-1:0] thr, input logic signed [FW-1:0] ne,
                              input logic signed [FW-1:0] ps, input logic [1:0] exp_st);
        logic [1:0] e;
        exp_q.push_back(exp_st);
        send_window(ll, thr, ne, ps);
        steps(2);
        e = exp_q.pop_front();
        check({name, "_state"}, 64'(state), 64'(e));
        check({name, "_stim"}, 64'(stimulation), 64'(e == 2'd2));
    endtask

    task automatic wait_state(input string name, input logic [1:0] st, input int budget);
        int n = 0;
        while (state != st && n < budget) begin
            step();
            n++;
        end
        check({name, "_reached"}, 64'(state == st), 64'd1);
    endtask

    initial begin
        tbl[0]  = '{HI_LL, THR_LL, HI_F, LO_F, 2'd1};
        tbl[1]  = '{HI_LL, THR_LL, HI_F, LO_F, 2'd1};
        tbl[2]  = '{HI_LL, THR_LL, LO_F, LO_F, 2'd0};
        tbl[3]  = '{HI_LL, THR_LL, HI_F, LO_F, 2'd1};
        tbl[4]  = '{25'sh0000100, 25'sh0000100, LO_F, LO_F, 2'd0};
        tbl[5]  = '{25'sh0000100, 25'sh0000100, HI_F, LO_F, 2'd0};
        tbl[6]  = '{-25'sd5, -25'sd6, HI_F, LO_F, 2'd1};
        tbl[7]  = '{-25'sd7, -25'sd6, HI_F, LO_F, 2'd0};
        tbl[8]  = '{-25'sd7, 25'sd5, HI_F, LO_F, 2'd0};
        tbl[9]  = '{25'sd5, -25'sd6, HI_F, LO_F, 2'd1};
        tbl[10] = '{LO_LL, THR_LL, HI_F, HI_F, 2'd1};

        rst = 1'b0;
        en  = 1'b0;
        feat.din_ll = '0; feat.din_ne = '0; feat.din_ps = '0;
        feat.data_ready_ll = 1'b0; feat.data_ready_ne = 1'b0; feat.data_ready_ps = 1'b0;
        feat.thr_ll = THR_LL; feat.thr_ne = THR_F; feat.thr_ps = THR_F;
        steps(3);
        check("reset_state", 64'(state), 64'd0);
        check("reset_stim", 64'(stimulation), 64'd0);
        check("reset_overrun", 64'(overrun), 64'd0);
        rst = 1'b1;
        step();

        // Vote, strict signed compare, consecutive-window arming
        for (int i = 0; i < 11; i++) begin
            run_window($sformatf("vec%0d", i), tbl[i].ll, tbl[i].thr, tbl[i].ne, tbl[i].ps, tbl[i].st);
        end

        // Third consecutive positive window fires two cycles after its last strobe
        stim_hi = 0;
        refr_hi = 0;
        exp_q.push_back(2'd2);
        send_window(HI_LL, THR_LL, HI_F, LO_F);
        step();
        check("fire_early_stim", 64'(stimulation), 64'd0);
        check("fire_early_state", 64'(state), 64'd1);
        step();
        check("fire_state", 64'(state), 64'(exp_q.pop_front()));
        check("fire_stim", 64'(stimulation), 64'd1);

        // Windows during STIM and REFRACT are ignored
        for (int i = 0; i < 3; i++) run_window($sformatf("in_stim%0d", i), HI_LL, THR_LL, HI_F, HI_F, 2'd2);
        wait_state("to_refract", 2'd3, 100);
        check("stim_duration", 64'(stim_hi), 64'(SC));
        for (int i = 0; i < 2; i++) run_window($sformatf("in_refr%0d", i), HI_LL, THR_LL, HI_F, HI_F, 2'd3);
        wait_state("to_idle", 2'd0, 200);
        check("refract_duration", 64'(refr_hi), 64'(RC));
        check("no_overrun_yet", 64'(ovr_cnt), 64'd0);
        run_window("rearm", HI_LL, THR_LL, HI_F, LO_F, 2'd1);

        // Double ne strobe: overrun pulse, second value wins
        ovr_cnt = 0;
        feat.thr_ll = THR_LL;
        strobe_ne(LO_F);
        strobe_ne(HI_F);
        check("overrun_pulse", 64'(overrun), 64'd1);
        strobe_ll(HI_LL);
        check("overrun_clear", 64'(overrun), 64'd0);
        strobe_ps(LO_F);
        steps(2);
        check("overrun_window", 64'(state), 64'd1);
        check("overrun_count", 64'(ovr_cnt), 64'd1);

        // Async reset mid-STIM drops stimulation and discards the partial window
        run_window("pre_reset_fire", HI_LL, THR_LL, HI_F, LO_F, 2'd2);
        steps(4);
        strobe_ll(HI_LL);
        rst = 1'b0;
        #1;
        check("rst_stim", 64'(stimulation), 64'd0);
        check("rst_state", 64'(state), 64'd0);
        step();
        rst = 1'b1;
        step();
        strobe_ne(HI_F);
        strobe_ps(HI_F);
        steps(2);
        check("partial_discarded", 64'(state), 64'd0);
        strobe_ll(LO_LL);
        steps(2);
        check("post_reset_window", 64'(state), 64'd1);

        // Freeze mid-STIM: output gated, counter held, total high time unchanged
        run_window("pre_freeze", HI_LL, THR_LL, HI_F, LO_F, 2'd1);
        stim_hi = 0;
        run_window("freeze_fire", HI_LL, THR_LL, HI_F, LO_F, 2'd2);
        steps(5);
        en = 1'b1;
        #1;
        check("freeze_stim", 64'(stimulation), 64'd0);
        steps(10);
        check("freeze_state", 64'(state), 64'd2);
        en = 1'b0;
        #1;
        check("unfreeze_stim", 64'(stimulation), 64'd1);
        wait_state("freeze_to_refract", 2'd3, 100);
        check("freeze_duration", 64'(stim_hi), 64'(SC));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
